// File: rtl/matrix_pkg.sv
// Shared scan-state type, default geometry and word-width helper for the LED matrix scanner.
package matrix_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StWait,
      StShift,
      StLatch,
      StDwell
   } scan_state_t;

   localparam int unsigned DefColW  = 16;
   localparam int unsigned DefRowN  = 8;
   localparam int unsigned DefDiv   = 2;
   localparam int unsigned DefDwell = 1024;

   // Serial word = row one-hot above the column data.
   function automatic int unsigned word_w(input int unsigned col_w, input int unsigned row_n);
      return col_w + row_n;
   endfunction

endpackage

// File: rtl/scan_shifter.sv
// Serialiser for the 595 chain: prescaled SH_CP/DS generation for one word, then an ST_CP latch
// pulse. Loads on start_i and pulses done_o in the last latch cycle.
module scan_shifter #(
   parameter int unsigned WORD_W = 24,
   parameter int unsigned DIV    = 2
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic [WORD_W-1:0] word_i,
   output logic              shift_end_o,
   output logic              done_o,
   output logic              sh_cp_o,
   output logic              st_cp_o,
   output logic              ds_o
);

   localparam int unsigned PreW = $clog2(DIV + 1);
   localparam int unsigned BitW = $clog2(WORD_W + 1);

   logic [WORD_W-1:0] word_q, word_d;
   logic [PreW-1:0]   pre_q, pre_d;
   logic [BitW-1:0]   bit_q, bit_d;
   logic              shift_q, shift_d;
   logic              high_q, high_d;
   logic              latch_q, latch_d;
   logic              pre_last, bit_last;

   assign pre_last = (pre_q == PreW'(DIV - 1));
   assign bit_last = (bit_q == BitW'(WORD_W - 1));

   always_comb begin
      word_d  = word_q;
      pre_d   = pre_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      high_d  = high_q;
      latch_d = latch_q;
      if (start_i) begin
         word_d  = word_i;
         shift_d = 1'b1;
         latch_d = 1'b0;
         high_d  = 1'b0;
         pre_d   = '0;
         bit_d   = '0;
      end else if (shift_q) begin
         if (pre_last) begin
            pre_d  = '0;
            high_d = ~high_q;
            // End of the high phase closes the bit period; next bit appears with SH_CP low.
            if (high_q) begin
               word_d = word_q >> 1;
               if (bit_last) begin
                  shift_d = 1'b0;
                  latch_d = 1'b1;
                  bit_d   = '0;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end else begin
            pre_d = pre_q + 1'b1;
         end
      end else if (latch_q) begin
         if (pre_last) begin
            pre_d   = '0;
            latch_d = 1'b0;
         end else begin
            pre_d = pre_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         word_q  <= '0;
         pre_q   <= '0;
         bit_q   <= '0;
         shift_q <= 1'b0;
         high_q  <= 1'b0;
         latch_q <= 1'b0;
      end else begin
         word_q  <= word_d;
         pre_q   <= pre_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         high_q  <= high_d;
         latch_q <= latch_d;
      end
   end

   assign sh_cp_o     = shift_q & high_q;
   assign ds_o        = shift_q & word_q[0];
   assign st_cp_o     = latch_q;
   assign shift_end_o = shift_q & high_q & pre_last & bit_last;
   assign done_o      = latch_q & pre_last;

endmodule

// File: rtl/matrix_scan_ctrl.sv
// Row-scan scheduler for a 595-chain LED matrix with frame-boundary bank swapping.
// Optional macro BRIGHTNESS_PWM_EN adds the brightness port and PWM-gated OE_N within the dwell.
module matrix_scan_ctrl
   import matrix_pkg::*;
#(
   parameter int unsigned COL_W = DefColW,
   parameter int unsigned ROW_N = DefRowN,
   parameter int unsigned DIV   = DefDiv,
   parameter int unsigned DWELL = DefDwell
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   input  logic                    enable,
   output logic                    fb_rd,
   output logic [$clog2(ROW_N):0]  fb_addr,
   input  logic [COL_W-1:0]        fb_data,
   input  logic                    frame_swap_req,
   output logic                    frame_swap_ack,
   output logic                    frame_done,
   output logic                    SH_CP,
   output logic                    ST_CP,
   output logic                    DS,
   output logic                    OE_N
`ifdef BRIGHTNESS_PWM_EN
   ,
   input  logic [3:0]              brightness
`endif
);

   localparam int unsigned WordW = word_w(COL_W, ROW_N);
   localparam int unsigned RowW  = $clog2(ROW_N);
   localparam int unsigned DwW   = $clog2(DWELL + 1);

   scan_state_t      state_q, state_d;
   logic [RowW-1:0]  row_q, row_d;
   logic             bank_q, bank_d;
   logic [DwW-1:0]   dwell_q, dwell_d;
   logic             frame_done_q, frame_done_d;
   logic             swap_ack_q, swap_ack_d;
   logic             sh_start, sh_shift_end, sh_done;
   logic [ROW_N-1:0] row_onehot;
   logic [WordW-1:0] word;
   logic [DwW-1:0]   on_len;
   logic             oe_on;

   assign row_onehot = ROW_N'(1) << row_q;
   assign word       = {row_onehot, fb_data};

`ifdef BRIGHTNESS_PWM_EN
   logic [3:0] bright_q;

   // Level is frozen for the whole dwell so a mid-row change cannot produce a runt pulse.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         bright_q <= '0;
      end else if (state_q == StLatch && sh_done) begin
         bright_q <= brightness;
      end
   end

   assign on_len = DwW'((32'(bright_q) + 32'd1) * (DWELL / 16));
`else
   assign on_len = DwW'(DWELL);
`endif

   assign oe_on = (dwell_q < on_len);

   always_comb begin
      state_d      = state_q;
      row_d        = row_q;
      bank_d       = bank_q;
      dwell_d      = dwell_q;
      frame_done_d = 1'b0;
      swap_ack_d   = 1'b0;
      sh_start     = 1'b0;
      case (state_q)
         StIdle:  if (enable) state_d = StFetch;
         StFetch: state_d = StWait;
         StWait: begin
            sh_start = 1'b1;
            state_d  = StShift;
         end
         StShift: if (sh_shift_end) state_d = StLatch;
         StLatch: begin
            if (sh_done) begin
               state_d = StDwell;
               dwell_d = '0;
            end
         end
         StDwell: begin
            if (dwell_q == DwW'(DWELL - 1)) begin
               state_d = enable ? StFetch : StIdle;
               // Bank only flips here, between frames, so a displayed frame never tears.
               if (row_q == RowW'(ROW_N - 1)) begin
                  row_d        = '0;
                  frame_done_d = 1'b1;
                  if (frame_swap_req) begin
                     bank_d     = ~bank_q;
                     swap_ack_d = 1'b1;
                  end
               end else begin
                  row_d = row_q + 1'b1;
               end
            end else begin
               dwell_d = dwell_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q      <= StIdle;
         row_q        <= '0;
         bank_q       <= 1'b0;
         dwell_q      <= '0;
         frame_done_q <= 1'b0;
         swap_ack_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         row_q        <= row_d;
         bank_q       <= bank_d;
         dwell_q      <= dwell_d;
         frame_done_q <= frame_done_d;
         swap_ack_q   <= swap_ack_d;
      end
   end

   scan_shifter #(
      .WORD_W (WordW),
      .DIV    (DIV)
   ) u_shifter (
      .clk_i       (CLK),
      .rst_ni      (RST_N),
      .start_i     (sh_start),
      .word_i      (word),
      .shift_end_o (sh_shift_end),
      .done_o      (sh_done),
      .sh_cp_o     (SH_CP),
      .st_cp_o     (ST_CP),
      .ds_o        (DS)
   );

   assign fb_rd          = (state_q == StFetch);
   assign fb_addr        = {bank_q, row_q};
   assign OE_N           = ~((state_q == StDwell) & oe_on);
   assign frame_done     = frame_done_q;
   assign frame_swap_ack = swap_ack_q;

endmodule
